scg_writeap_brst: RTL and testbench
===================================

Name: scg_writeap_brst

Overview:
Burst write with auto-precharge command sequence FSM. It is the write-direction counterpart of the burst-read-with-auto-precharge sequencer in the SDRAM controller command-sequence-generator (scg_) family. On start it issues one WRITEA command, then drives write data for BURST_LEN beats, waits tWR and tRP, and reports done. The top-level controller FSM launches it, and its command/data-enable outputs are muxed onto the SDRAM pins.

Parameters:
BURST_LEN, 4, data beats per burst; legal values 1, 2, 4, 8
TWR, 2, write-recovery cycles after last data beat; legal 1..15
TRP, 3, precharge cycles after tWR before done; legal 1..15

Ports:
clk  input  1  system clock, all state updates on rising edge
n_rst  input  1  asynchronous active-low reset
start  input  1  level request from controller; held high until done seen
done  output  1  high while in DONE state
command  output  4  SDRAM command code: 0 = NOP, 3 = WRITEA; all other codes unused
data_oe  output  1  drive DQ with write data this cycle
beat  output  3  index of write word to present on DQ (0..BURST_LEN-1); 0 when data_oe low

Behaviour:
- Reset (n_rst low, async): state IDLE, counter 0. Outputs: done=0, command=0, data_oe=0, beat=0. Reset mid-burst aborts immediately; no further commands are issued.
- States: IDLE, CMD, DATA, WREC, PRECH, DONE. One 4-bit down/up counter serves DATA, WREC and PRECH.
- IDLE: start=1 -> CMD; otherwise stay.
- CMD: lasts 1 cycle; command=3, data_oe=1, beat=0 (zero write latency: first word accompanies WRITEA).
  - BURST_LEN=1 -> WREC, counter loads TWR-1.
  - Else -> DATA, beat counter=1.
- DATA: command=0, data_oe=1, beat=counter. Counter increments each cycle.
  - When beat = BURST_LEN-1 -> WREC, counter loads TWR-1.
- WREC: command=0, data_oe=0. Counter decrements; at 0 -> PRECH, counter loads TRP-1.
- PRECH: command=0, data_oe=0. Counter decrements; at 0 -> DONE.
- DONE: done=1. start=0 -> IDLE; start=1 -> stay in DONE (no retrigger until start drops).
- start deasserted anywhere from CMD through PRECH: ignored; the sequence completes.
- Outputs are Moore, decoded from registered state and counter only; no combinational path from start.
- Latency: start sampled at edge 0 -> CMD in cycle 1. DONE entered at cycle 1 + BURST_LEN + TWR + TRP (defaults: cycle 10).
- Exactly one nonzero command per sequence. data_oe is high for exactly BURST_LEN consecutive cycles, starting with CMD.

Test Plan:
- Reset: n_rst low mid-DATA (defaults) -> same-cycle command=0, data_oe=0, done=0, beat=0; after release with start=0, stays IDLE.
- Default burst: start=1 at edge 0 -> cycle 1 command=3, data_oe=1, beat=0; cycles 2-4 beat=1,2,3, data_oe=1, command=0; cycles 5-9 data_oe=0, command=0; cycle 10 done=1.
- Hold in DONE: keep start=1 for 5 cycles after done -> done stays 1, command stays 0. Drop start -> next cycle done=0 (IDLE). Raise start again -> new WRITEA 1 cycle later.
- Early start drop: start high for 1 cycle only -> full sequence still runs; DONE reached at cycle 10, then IDLE on the next cycle.
- BURST_LEN=1, TWR=1, TRP=1: start at edge 0 -> cycle 1 command=3, data_oe=1, beat=0; cycles 2-3 idle outputs; cycle 4 done=1.
- BURST_LEN=8, TWR=15, TRP=15: beat counts 0..7 over cycles 1-8; done first asserted at cycle 39; count of nonzero command cycles = 1.

Source files
------------

// File: rtl/scg_writeap_brst.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// scg_writeap_brst
//
// Command-sequence generator for one SDRAM burst write with auto-precharge.
// It is the write-direction sibling of the burst-read-with-auto-precharge
// sequencer. When the controller raises start, the block issues a single
// WRITEA, presents BURST_LEN data beats (the first one together with WRITEA,
// because write latency is zero), then waits out write recovery (TWR) and
// the precharge time (TRP) before raising done. done stays high until the
// controller drops start, so one request can never launch two sequences.
//
// Parameters
//   BURST_LEN  data beats per burst (1, 2, 4 or 8)
//   TWR        write-recovery cycles after the last data beat (1..15)
//   TRP        precharge cycles after write recovery (1..15)
//
// Ports
//   clk      system clock, rising-edge active
//   n_rst    asynchronous active-low reset
//   start    level request from the controller, held until done is seen
//   done     high while the sequence sits in its DONE state
//   command  SDRAM command code: 0 = NOP, 3 = WRITEA
//   data_oe  drive DQ with write data this cycle
//   beat     index of the write word to present on DQ, 0 when data_oe is low
// ---------------------------------------------------------------------------
module scg_writeap_brst #(
  parameter int BURST_LEN = 4,
  parameter int TWR       = 2,
  parameter int TRP       = 3
) (
  input  logic       clk,
  input  logic       n_rst,
  input  logic       start,
  output logic       done,
  output logic [3:0] command,
  output logic       data_oe,
  output logic [2:0] beat
);

  typedef enum logic [2:0] {
    IDLE,
    CMD,
    DATA,
    WREC,
    PRECH,
    DONE
  } state_t;

  localparam logic [3:0] CMD_NOP    = 4'd0;
  localparam logic [3:0] CMD_WRITEA = 4'd3;

  // Counter reload values. The counters stop at zero, so a wait of N
  // cycles loads N-1.
  localparam logic [3:0] LAST_BEAT = 4'(BURST_LEN - 1);
  localparam logic [3:0] TWR_LOAD  = 4'(TWR - 1);
  localparam logic [3:0] TRP_LOAD  = 4'(TRP - 1);

  state_t     state;
  state_t     state_n;
  logic [3:0] count;
  logic [3:0] count_n;

  // Next-state and next-count logic. One 4-bit counter is shared by the
  // three timed phases: it counts up through the data beats (so it can
  // drive beat directly), then down through TWR and then TRP.
  // start only matters in IDLE (launch) and DONE (release); in every
  // other state the sequence runs to completion regardless of start.
  always_comb begin
    state_n = state;
    count_n = count;
    unique case (state)
      IDLE: begin
        count_n = 4'd0;
        if (start) begin
          state_n = CMD;
        end
      end
      CMD: begin
        if (BURST_LEN == 1) begin
          state_n = WREC;
          count_n = TWR_LOAD;
        end else begin
          state_n = DATA;
          count_n = 4'd1;
        end
      end
      DATA: begin
        if (count == LAST_BEAT) begin
          state_n = WREC;
          count_n = TWR_LOAD;
        end else begin
          count_n = count + 4'd1;
        end
      end
      WREC: begin
        if (count == 4'd0) begin
          state_n = PRECH;
          count_n = TRP_LOAD;
        end else begin
          count_n = count - 4'd1;
        end
      end
      PRECH: begin
        if (count == 4'd0) begin
          state_n = DONE;
          count_n = 4'd0;
        end else begin
          count_n = count - 4'd1;
        end
      end
      DONE: begin
        count_n = 4'd0;
        if (!start) begin
          state_n = IDLE;
        end
      end
      default: begin
        state_n = IDLE;
        count_n = 4'd0;
      end
    endcase
  end

  // State, counter and output registers. Outputs are decoded from the
  // state/counter value being loaded, so each output register always
  // matches the state register it sits beside and nothing reaches the
  // pins combinationally from start. The asynchronous reset clears the
  // outputs at once, which aborts a burst mid-flight with no further
  // command or data drive.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state   <= IDLE;
      count   <= 4'd0;
      done    <= 1'b0;
      command <= CMD_NOP;
      data_oe <= 1'b0;
      beat    <= 3'd0;
    end else begin
      state   <= state_n;
      count   <= count_n;
      done    <= (state_n == DONE);
      command <= (state_n == CMD) ? CMD_WRITEA : CMD_NOP;
      data_oe <= (state_n == CMD) || (state_n == DATA);
      beat    <= (state_n == DATA) ? count_n[2:0] : 3'd0;
    end
  end

endmodule

// File: tb/tb_scg_writeap_brst.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// tb_scg_writeap_brst
//
// Drives three copies of the write-with-auto-precharge sequencer: the
// default configuration, the shortest (1/1/1) and the longest (8/15/15).
// A reference model tracks each copy as "cycles since launch" and derives
// the expected pins from that number with plain arithmetic.
// ---------------------------------------------------------------------------
module tb_scg_writeap_brst;

  logic       clk = 1'b0;
  logic       n_rst;
  logic       st   [3];
  logic       dn   [3];
  logic [3:0] cmd  [3];
  logic       oe   [3];
  logic [2:0] bt   [3];

  int checks   = 0;
  int failures = 0;

  // Per-instance burst length and the launch-relative cycle of DONE.
  int bl  [3] = '{4, 1, 8};
  int tot [3] = '{1 + 4 + 2 + 3, 1 + 1 + 1 + 1, 1 + 8 + 15 + 15};
  int ph  [3];

  always #5 clk = ~clk;

  scg_writeap_brst u_def (
    .clk(clk), .n_rst(n_rst), .start(st[0]), .done(dn[0]),
    .command(cmd[0]), .data_oe(oe[0]), .beat(bt[0])
  );

  scg_writeap_brst #(.BURST_LEN(1), .TWR(1), .TRP(1)) u_min (
    .clk(clk), .n_rst(n_rst), .start(st[1]), .done(dn[1]),
    .command(cmd[1]), .data_oe(oe[1]), .beat(bt[1])
  );

  scg_writeap_brst #(.BURST_LEN(8), .TWR(15), .TRP(15)) u_max (
    .clk(clk), .n_rst(n_rst), .start(st[2]), .done(dn[2]),
    .command(cmd[2]), .data_oe(oe[2]), .beat(bt[2])
  );

  // Reference model: phase 0 means idle, otherwise phase is the number of
  // cycles since the launching edge. The sequence advances one phase per
  // cycle up to DONE, then stays there while start is held.
  function automatic int next_phase(int p, logic s, int t);
    if (p == 0) return s ? 1 : 0;
    if (p < t) return p + 1;
    return s ? t : 0;
  endfunction

  function automatic logic [3:0] exp_cmd(int p);
    return (p == 1) ? 4'd3 : 4'd0;
  endfunction

  function automatic logic exp_oe(int p, int b);
    return (p >= 1) && (p <= b);
  endfunction

  function automatic logic [2:0] exp_beat(int p, int b);
    return ((p >= 1) && (p <= b)) ? 3'(p - 1) : 3'd0;
  endfunction

  always @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      for (int i = 0; i < 3; i++) ph[i] = 0;
    end else begin
      for (int i = 0; i < 3; i++) ph[i] = next_phase(ph[i], st[i], tot[i]);
    end
  end

  // Reset held from time zero, then reset asserted in the middle of a
  // data phase must clear every output immediately.
  task automatic test_reset();
    n_rst = 1'b0;
    for (int i = 0; i < 3; i++) st[i] = 1'b0;
    repeat (3) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (dn[i] !== 1'b0 || cmd[i] !== 4'd0 || oe[i] !== 1'b0 || bt[i] !== 3'd0) begin
        failures++;
        $display("[TB] FAIL reset_state inst=%0d got done=%b cmd=%0d oe=%b beat=%0d want 0/0/0/0",
                 i, dn[i], cmd[i], oe[i], bt[i]);
      end
    end
    n_rst = 1'b1;
    @(negedge clk);
    st[0] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (oe[0] !== 1'b1 || bt[0] !== 3'd1) begin
      failures++;
      $display("[TB] FAIL reset_pre_data got oe=%b beat=%0d want oe=1 beat=1", oe[0], bt[0]);
    end
    #2 n_rst = 1'b0;
    #1;
    checks++;
    if (dn[0] !== 1'b0 || cmd[0] !== 4'd0 || oe[0] !== 1'b0 || bt[0] !== 3'd0) begin
      failures++;
      $display("[TB] FAIL reset_mid_data got done=%b cmd=%0d oe=%b beat=%0d want 0/0/0/0",
               dn[0], cmd[0], oe[0], bt[0]);
    end
    st[0] = 1'b0;
    @(negedge clk);
    n_rst = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      checks++;
      if (dn[0] !== 1'b0 || cmd[0] !== 4'd0 || oe[0] !== 1'b0) begin
        failures++;
        $display("[TB] FAIL reset_stay_idle cycle=%0d got done=%b cmd=%0d oe=%b want 0/0/0",
                 c, dn[0], cmd[0], oe[0]);
      end
    end
  endtask

  // Default burst with start held: leaves the instance sitting in DONE.
  task automatic test_default_burst();
    int         cmd_tab  [10] = '{3, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    logic       oe_tab   [10] = '{1, 1, 1, 1, 0, 0, 0, 0, 0, 0};
    int         beat_tab [10] = '{0, 1, 2, 3, 0, 0, 0, 0, 0, 0};
    logic       done_tab [10] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 1};
    st[0] = 1'b1;
    @(posedge clk);
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      checks++;
      if (cmd[0] !== 4'(cmd_tab[c]) || oe[0] !== oe_tab[c] ||
          bt[0] !== 3'(beat_tab[c]) || dn[0] !== done_tab[c]) begin
        failures++;
        $display("[TB] FAIL default_burst cycle=%0d got cmd=%0d oe=%b beat=%0d done=%b want cmd=%0d oe=%b beat=%0d done=%b",
                 c + 1, cmd[0], oe[0], bt[0], dn[0], cmd_tab[c], oe_tab[c], beat_tab[c], done_tab[c]);
      end
    end
  endtask

  // DONE holds while start stays high, releases on start low, and a new
  // request afterwards launches a fresh WRITEA.
  task automatic test_hold_done();
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      checks++;
      if (dn[0] !== 1'b1 || cmd[0] !== 4'd0) begin
        failures++;
        $display("[TB] FAIL hold_done cycle=%0d got done=%b cmd=%0d want done=1 cmd=0", c, dn[0], cmd[0]);
      end
    end
    st[0] = 1'b0;
    @(negedge clk);
    checks++;
    if (dn[0] !== 1'b0 || cmd[0] !== 4'd0) begin
      failures++;
      $display("[TB] FAIL release_done got done=%b cmd=%0d want done=0 cmd=0", dn[0], cmd[0]);
    end
    st[0] = 1'b1;
    @(negedge clk);
    checks++;
    if (cmd[0] !== 4'd3 || oe[0] !== 1'b1) begin
      failures++;
      $display("[TB] FAIL retrigger got cmd=%0d oe=%b want cmd=3 oe=1", cmd[0], oe[0]);
    end
    st[0] = 1'b0;
    repeat (10) @(negedge clk);
    checks++;
    if (dn[0] !== 1'b0 || cmd[0] !== 4'd0 || oe[0] !== 1'b0) begin
      failures++;
      $display("[TB] FAIL retrigger_return got done=%b cmd=%0d oe=%b want 0/0/0", dn[0], cmd[0], oe[0]);
    end
  endtask

  // start high for a single cycle still runs the whole sequence.
  task automatic test_early_drop();
    st[0] = 1'b1;
    @(posedge clk);
    #1 st[0] = 1'b0;
    for (int c = 1; c <= 11; c++) begin
      @(negedge clk);
      checks++;
      if (dn[0] !== (c == 10) || cmd[0] !== ((c == 1) ? 4'd3 : 4'd0) || oe[0] !== (c <= 4)) begin
        failures++;
        $display("[TB] FAIL early_drop cycle=%0d got done=%b cmd=%0d oe=%b want done=%b cmd=%0d oe=%b",
                 c, dn[0], cmd[0], oe[0], (c == 10), (c == 1) ? 3 : 0, (c <= 4));
      end
    end
  endtask

  // Single-beat burst with minimum recovery and precharge.
  task automatic test_short();
    logic [3:0] c_tab [5] = '{4'd3, 4'd0, 4'd0, 4'd0, 4'd0};
    logic       o_tab [5] = '{1, 0, 0, 0, 0};
    logic       d_tab [5] = '{0, 0, 0, 1, 0};
    st[1] = 1'b1;
    @(posedge clk);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      checks++;
      if (cmd[1] !== c_tab[c] || oe[1] !== o_tab[c] || bt[1] !== 3'd0 || dn[1] !== d_tab[c]) begin
        failures++;
        $display("[TB] FAIL short_burst cycle=%0d got cmd=%0d oe=%b beat=%0d done=%b want cmd=%0d oe=%b beat=0 done=%b",
                 c + 1, cmd[1], oe[1], bt[1], dn[1], c_tab[c], o_tab[c], d_tab[c]);
      end
      if (c == 3) st[1] = 1'b0;
    end
  endtask

  // Eight beats with maximum recovery and precharge.
  task automatic test_long();
    int ncmd = 0;
    int first_done = 0;
    st[2] = 1'b1;
    @(posedge clk);
    for (int c = 1; c <= 45; c++) begin
      @(negedge clk);
      if (cmd[2] !== 4'd0) ncmd++;
      if (dn[2] === 1'b1 && first_done == 0) first_done = c;
      if (c <= 8) begin
        checks++;
        if (oe[2] !== 1'b1 || bt[2] !== 3'(c - 1)) begin
          failures++;
          $display("[TB] FAIL long_beat cycle=%0d got oe=%b beat=%0d want oe=1 beat=%0d", c, oe[2], bt[2], c - 1);
        end
      end else if (c < 39) begin
        checks++;
        if (oe[2] !== 1'b0 || dn[2] !== 1'b0) begin
          failures++;
          $display("[TB] FAIL long_wait cycle=%0d got oe=%b done=%b want 0/0", c, oe[2], dn[2]);
        end
      end
      if (c == 39) st[2] = 1'b0;
    end
    checks++;
    if (first_done != 39) begin
      failures++;
      $display("[TB] FAIL long_done_cycle got %0d want 39", first_done);
    end
    checks++;
    if (ncmd != 1) begin
      failures++;
      $display("[TB] FAIL long_cmd_count got %0d want 1", ncmd);
    end
  endtask

  // Random start levels on all three instances plus occasional resets,
  // every output checked against the model every cycle.
  task automatic test_random();
    for (int c = 0; c < 600; c++) begin
      @(negedge clk);
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (cmd[i] !== exp_cmd(ph[i]) || oe[i] !== exp_oe(ph[i], bl[i]) ||
            bt[i] !== exp_beat(ph[i], bl[i]) || dn[i] !== (ph[i] == tot[i])) begin
          failures++;
          $display("[TB] FAIL random cycle=%0d inst=%0d phase=%0d got cmd=%0d oe=%b beat=%0d done=%b want cmd=%0d oe=%b beat=%0d done=%b",
                   c, i, ph[i], cmd[i], oe[i], bt[i], dn[i], exp_cmd(ph[i]),
                   exp_oe(ph[i], bl[i]), exp_beat(ph[i], bl[i]), (ph[i] == tot[i]));
        end
      end
      if ($urandom_range(0, 79) == 0) begin
        n_rst = 1'b0;
        #1;
        for (int i = 0; i < 3; i++) begin
          checks++;
          if (cmd[i] !== 4'd0 || oe[i] !== 1'b0 || bt[i] !== 3'd0 || dn[i] !== 1'b0) begin
            failures++;
            $display("[TB] FAIL random_reset cycle=%0d inst=%0d got cmd=%0d oe=%b beat=%0d done=%b want 0/0/0/0",
                     c, i, cmd[i], oe[i], bt[i], dn[i]);
          end
        end
        #1 n_rst = 1'b1;
      end
      for (int i = 0; i < 3; i++) st[i] = 1'($urandom_range(0, 1));
    end
  endtask

  initial begin
    test_reset();
    test_default_burst();
    test_hold_done();
    test_early_drop();
    test_short();
    test_long();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
